// File: rtl/mmcm_reconfig_pkg.sv
// Shared definitions for the MMCM reconfiguration scheduler: FSM encodings and
// the layout of a stored RCREG profile (12 records of 48 bits each).
package mmcm_reconfig_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_WAIT_RDY  = 3'd2,
        ST_START     = 3'd3,
        ST_WAIT_ACC  = 3'd4,
        ST_WAIT_DONE = 3'd5,
        ST_DONE      = 3'd6
    } sched_state_e;

    localparam int REC_W      = 48;
    localparam int REC_N      = 12;
    localparam int PROFILE_W  = REC_W * REC_N;
    localparam int DADDR_HI   = 38;
    localparam int DADDR_LO   = 32;
    localparam int BITMASK_HI = 31;
    localparam int BITMASK_LO = 16;
    localparam int BITSET_HI  = 15;
    localparam int BITSET_LO  = 0;

    function automatic logic [REC_W-1:0] profile_rec(input logic [PROFILE_W-1:0] prof,
                                                     input int unsigned n);
        return prof[n*REC_W +: REC_W];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr,
// ascending with wrap. The pointer register lives in the parent.
module rr_arbiter #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  logic         en,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx
);

    logic found;
    int   pos;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int i = 0; i < N; i++) begin
            pos = (int'(ptr) + i) % N;
            if (en && !found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = W'(pos);
            end
        end
    end

endmodule

// File: rtl/mmcm_reconfig_sched.sv
// Round-robin sequencer in front of the MMCM DRP reconfiguration engine: selects
// a profile, starts the engine via RCEN/RCRDY and guards it with a watchdog.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | no grant; arbitrate pending requests
// ST_SETUP     | profile mux settling; skip if profile already applied
// ST_WAIT_RDY  | waiting for engine idle-and-locked
// ST_START     | RCEN pulse
// ST_WAIT_ACC  | waiting for engine to drop RCRDY (accepted)
// ST_WAIT_DONE | waiting for RCRDY high again (rewritten and relocked)
// ST_DONE      | ACK pulse to the granted requester
module mmcm_reconfig_sched
    import mmcm_reconfig_pkg::*;
#(
    parameter  int N_REQ   = 4,
    parameter  int PROF_W  = 3,
    parameter  int TMO_CYC = 1000000,
    localparam int GNT_W   = $clog2(N_REQ),
    localparam int WD_W    = $clog2(TMO_CYC)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*PROF_W-1:0]   req_prof,
    output logic [N_REQ-1:0]          ack,
    output logic                      err,
    output logic                      busy,
    output logic [GNT_W-1:0]          gnt_id,
    output logic [PROF_W-1:0]         prof_idx,
    output logic                      rcen,
    input  logic                      rcrdy,
    output logic [PROF_W-1:0]         cur_prof,
    output logic                      cur_valid
);

    localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TMO_CYC - 1);
    localparam logic [GNT_W-1:0] LAST_REQ = GNT_W'(N_REQ - 1);

    sched_state_e     state, state_nx;
    logic [GNT_W-1:0] ptr;
    logic [N_REQ-1:0] gnt_oh;
    logic [WD_W-1:0]  wdog;
    logic [N_REQ-1:0] arb_gnt;
    logic [GNT_W-1:0] arb_idx;
    logic             arb_en;
    logic             grant;
    logic             counting;
    logic             tmo_hit;

    assign arb_en   = (state == ST_IDLE);
    assign grant    = arb_en && (|req);
    assign counting = (state == ST_WAIT_RDY) || (state == ST_START) ||
                      (state == ST_WAIT_ACC) || (state == ST_WAIT_DONE);
    assign tmo_hit  = counting && (wdog == WD_MAX);

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req (req),
        .ptr (ptr),
        .en  (arb_en),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:      if (|req) state_nx = ST_SETUP;
            ST_SETUP:     state_nx = (cur_valid && prof_idx == cur_prof) ? ST_DONE : ST_WAIT_RDY;
            ST_WAIT_RDY:  if (tmo_hit) state_nx = ST_DONE;
                          else if (rcrdy) state_nx = ST_START;
            ST_START:     state_nx = tmo_hit ? ST_DONE : ST_WAIT_ACC;
            ST_WAIT_ACC:  if (tmo_hit) state_nx = ST_DONE;
                          else if (!rcrdy) state_nx = ST_WAIT_DONE;
            ST_WAIT_DONE: if (tmo_hit || rcrdy) state_nx = ST_DONE;
            ST_DONE:      state_nx = ST_IDLE;
            default:      state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            gnt_oh    <= '0;
            gnt_id    <= '0;
            prof_idx  <= '0;
            busy      <= 1'b0;
            rcen      <= 1'b0;
            ack       <= '0;
            err       <= 1'b0;
            cur_prof  <= '0;
            cur_valid <= 1'b0;
            wdog      <= '0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx != ST_IDLE);
            rcen  <= (state_nx == ST_START);
            ack   <= (state_nx == ST_DONE) ? gnt_oh : '0;
            err   <= (state_nx == ST_DONE) && tmo_hit;

            if (grant) begin
                gnt_oh   <= arb_gnt;
                gnt_id   <= arb_idx;
                prof_idx <= req_prof[int'(arb_idx)*PROF_W +: PROF_W];
                ptr      <= (arb_idx == LAST_REQ) ? '0 : arb_idx + 1'b1;
            end

            if (state == ST_SETUP && state_nx == ST_WAIT_RDY)
                wdog <= '0;
            else if (counting && wdog != WD_MAX)
                wdog <= wdog + 1'b1;

            // A timeout leaves the MMCM in an unknown configuration.
            if (tmo_hit)
                cur_valid <= 1'b0;
            else if (state == ST_WAIT_DONE && rcrdy) begin
                cur_prof  <= prof_idx;
                cur_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mmcm_reconfig_sched.sv
// Scoreboard bench for mmcm_reconfig_sched with a behavioural DRP engine model.
module tb_mmcm_reconfig_sched;

    localparam int N_REQ   = 4;
    localparam int PROF_W  = 3;
    localparam int TMO_CYC = 100;
    localparam int ENG_NORMAL = 0;
    localparam int ENG_HANG   = 1;
    localparam int ENG_MANUAL = 2;

    typedef struct {
        int id;
        int prof;
        int err;
        int rcen_n;
        int cur_prof;
        int cur_valid;
        int ack_lat;
        int rcen_lat;
    } exp_t;

    logic                     clk;
    logic                     rst_n;
    logic [N_REQ-1:0]         req;
    logic [N_REQ*PROF_W-1:0]  req_prof;
    logic [N_REQ-1:0]         ack;
    logic                     err;
    logic                     busy;
    logic [1:0]               gnt_id;
    logic [PROF_W-1:0]        prof_idx;
    logic                     rcen;
    logic                     rcrdy;
    logic [PROF_W-1:0]        cur_prof;
    logic                     cur_valid;

    int   checks = 0;
    int   errors = 0;
    int   eng_mode = ENG_NORMAL;
    logic man_lvl = 1'b1;
    int   eng_cnt;
    exp_t exp_q[$];

    mmcm_reconfig_sched #(.N_REQ(N_REQ), .PROF_W(PROF_W), .TMO_CYC(TMO_CYC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_prof  (req_prof),
        .ack       (ack),
        .err       (err),
        .busy      (busy),
        .gnt_id    (gnt_id),
        .prof_idx  (prof_idx),
        .rcen      (rcen),
        .rcrdy     (rcrdy),
        .cur_prof  (cur_prof),
        .cur_valid (cur_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic push(input int id, input int prof, input int e, input int rn,
                        input int cp, input int cv, input int al, input int rl);
        exp_t x;
        x.id = id; x.prof = prof; x.err = e; x.rcen_n = rn;
        x.cur_prof = cp; x.cur_valid = cv; x.ack_lat = al; x.rcen_lat = rl;
        exp_q.push_back(x);
    endtask

    task automatic set_prof(input int id, input int p);
        req_prof[id*PROF_W +: PROF_W] = PROF_W'(p);
    endtask

    // Waits for n ACKs; drops each acked request at the following edge, or
    // with hold=1 keeps everything high until the last ACK.
    task automatic serve(input int n, input bit hold);
        int cnt = 0;
        int cyc = 0;
        logic [N_REQ-1:0] a;
        while (cnt < n && cyc < 400 * n) begin
            @(negedge clk);
            cyc++;
            if (|ack) begin
                cnt++;
                a = ack;
                if (!hold || cnt == n) begin
                    @(posedge clk);
                    #1;
                    req = hold ? '0 : (req & ~a);
                end
            end
        end
        chk("serve_ack_count", cnt, n);
        if (cnt != n) req = '0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Engine model: drops RCRDY ~2 cycles after RCEN, raises it 50 cycles later.
    initial begin
        rcrdy   = 1'b1;
        eng_cnt = 0;
        forever begin
            @(negedge clk);
            if (eng_mode == ENG_MANUAL) begin
                rcrdy   = man_lvl;
                eng_cnt = 0;
            end else begin
                if (rcen) eng_cnt = 1;
                else if (eng_cnt > 0) eng_cnt++;
                if (eng_cnt == 2) rcrdy = 1'b0;
                if (eng_cnt == 52) begin
                    if (eng_mode == ENG_NORMAL) rcrdy = 1'b1;
                    eng_cnt = 0;
                end
            end
        end
    end

    // Monitor: checks grants against the queue head and pops on ACK.
    initial begin
        int   cyc = 0;
        int   bstart = 0;
        int   rcen_n = 0;
        int   rcen_first = -1;
        bit   prof_bad = 0;
        bit   rcen_bad = 0;
        logic busy_q = 1'b0;
        logic [PROF_W-1:0] prof_lat = '0;
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                busy_q = 1'b0;
                continue;
            end
            if (busy && !busy_q) begin
                bstart = cyc; rcen_n = 0; rcen_first = -1;
                prof_bad = 0; rcen_bad = 0; prof_lat = prof_idx;
                if (exp_q.size() == 0) chk("unexpected_grant", 1, 0);
                else begin
                    chk("gnt_id", gnt_id, exp_q[0].id);
                    chk("prof_idx", prof_idx, exp_q[0].prof);
                end
            end
            if (busy) begin
                if (prof_idx != prof_lat) prof_bad = 1;
                if (rcen) begin
                    rcen_n++;
                    if (rcen_first < 0) rcen_first = cyc - bstart;
                    if (!rcrdy) rcen_bad = 1;
                end
            end
            if (|ack) begin
                if (exp_q.size() == 0) chk("unexpected_ack", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("ack_vec", ack, 1 << e.id);
                    chk("err", err, e.err);
                    chk("rcen_pulses", rcen_n, e.rcen_n);
                    chk("cur_prof", cur_prof, e.cur_prof);
                    chk("cur_valid", cur_valid, e.cur_valid);
                    chk("prof_stable", prof_bad, 0);
                    chk("rcen_while_not_ready", rcen_bad, 0);
                    if (e.ack_lat >= 0) chk("ack_latency", cyc - bstart, e.ack_lat);
                    if (e.rcen_lat >= 0) chk("rcen_latency", rcen_first, e.rcen_lat);
                end
            end
            busy_q = busy;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int w;
        rst_n = 1'b0;
        req = '0;
        req_prof = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {ack, err, busy, gnt_id, prof_idx, rcen, cur_prof, cur_valid}, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single request with full reconfiguration.
        push(1, 3, 0, 1, 3, 1, -1, 2);
        set_prof(1, 3); req[1] = 1'b1;
        serve(1, 0);

        // Redundant requests for the applied profile skip the engine.
        push(2, 3, 0, 0, 3, 1, 1, -1);
        set_prof(2, 3); req[2] = 1'b1;
        serve(1, 0);
        push(3, 3, 0, 0, 3, 1, 1, -1);
        set_prof(3, 3); req[3] = 1'b1;
        serve(1, 0);

        // Round robin with all requests held: 0,1,2,3,0.
        set_prof(0, 1); set_prof(1, 2); set_prof(2, 4); set_prof(3, 5);
        push(0, 1, 0, 1, 1, 1, -1, 2);
        push(1, 2, 0, 1, 2, 1, -1, 2);
        push(2, 4, 0, 1, 4, 1, -1, 2);
        push(3, 5, 0, 1, 5, 1, -1, 2);
        push(0, 1, 0, 1, 1, 1, -1, 2);
        req = 4'b1111;
        serve(5, 1);

        // Engine accepts but never relocks: watchdog fires.
        eng_mode = ENG_HANG;
        push(1, 6, 1, 1, 1, 0, TMO_CYC + 1, 2);
        set_prof(1, 6); req[1] = 1'b1;
        serve(1, 0);
        eng_mode = ENG_MANUAL; man_lvl = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        eng_mode = ENG_NORMAL;
        push(2, 6, 0, 1, 6, 1, -1, 2);
        set_prof(2, 6); req[2] = 1'b1;
        serve(1, 0);

        // Engine busy at grant: RCEN must wait for RCRDY.
        eng_mode = ENG_MANUAL; man_lvl = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        push(0, 2, 0, 1, 2, 1, -1, -1);
        set_prof(0, 2); req[0] = 1'b1;
        w = 0;
        while (!busy && w < 20) begin @(negedge clk); w++; end
        chk("grant_seen_t5", busy, 1);
        repeat (30) @(posedge clk);
        #1;
        man_lvl = 1'b1;
        @(posedge clk);
        #1;
        eng_mode = ENG_NORMAL;
        serve(1, 0);

        // Reset while waiting for relock.
        push(1, 7, 0, 1, 7, 1, -1, 2);
        set_prof(1, 7); req[1] = 1'b1;
        w = 0;
        while (!rcen && w < 50) begin @(negedge clk); w++; end
        chk("rcen_seen_t6", rcen, 1);
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midflight_reset_outputs", {ack, err, busy, gnt_id, prof_idx, rcen, cur_prof, cur_valid}, 0);
        req = '0;
        chk("aborted_request_no_ack", exp_q.size(), 1);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        push(1, 7, 0, 1, 7, 1, -1, 2);
        push(3, 4, 0, 1, 4, 1, -1, 2);
        set_prof(1, 7); set_prof(3, 4);
        req = 4'b1010;
        serve(2, 0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
